// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, legality limits and byte-lane merge for sram_dp_ff
package sram_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } write_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clear_state_e;

  localparam int MinReadLatency = 1;
  localparam int MaxReadLatency = 4;
  localparam int MaxDataWidth   = 512;
  localparam int MaxBeWidth     = MaxDataWidth / 8;

  typedef logic [MaxDataWidth-1:0] word_max_t;
  typedef logic [MaxBeWidth-1:0]   be_max_t;

  // Lanes with be set take new_w, all others keep old_w; callers zero-extend narrower words.
  function automatic word_max_t be_merge(word_max_t old_w, word_max_t new_w, be_max_t be);
    word_max_t r;
    r = old_w;
    for (int i = 0; i < MaxBeWidth; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - fixed-latency response pipeline; rdata holds its last delivered value
module sram_rd_pipe #(
  parameter int ReadLatency = 1,
  parameter int DataWidth   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid,
  input  logic [DataWidth-1:0] in_data,
  output logic                 rvalid,
  output logic [DataWidth-1:0] rdata
);

  logic [ReadLatency-1:0] vld_q;
  logic [DataWidth-1:0]   dat_q [ReadLatency];

  // Each data stage only loads behind a valid, so the last stage naturally holds between pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < ReadLatency; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) dat_q[0] <= in_data;
      for (int i = 1; i < ReadLatency; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rvalid = vld_q[ReadLatency-1];
  assign rdata  = dat_q[ReadLatency-1];

endmodule

// File: rtl/sram_dp_ff.sv
// rtl/sram_dp_ff.sv - true dual-port flop SRAM with fixed read latency and sequential clear engine
module sram_dp_ff
  import sram_pkg::*;
#(
  parameter int AddrWidth   = 11,
  parameter int DataWidth   = 32,
  parameter int ReadLatency = 1,
  parameter int WriteMode   = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   a_req_i,
  output logic                   a_gnt_o,
  input  logic                   a_we_i,
  input  logic [DataWidth/8-1:0] a_be_i,
  input  logic [AddrWidth-1:0]   a_addr_i,
  input  logic [DataWidth-1:0]   a_wdata_i,
  output logic                   a_rvalid_o,
  output logic [DataWidth-1:0]   a_rdata_o,
  input  logic                   b_req_i,
  output logic                   b_gnt_o,
  input  logic                   b_we_i,
  input  logic [DataWidth/8-1:0] b_be_i,
  input  logic [AddrWidth-1:0]   b_addr_i,
  input  logic [DataWidth-1:0]   b_wdata_i,
  output logic                   b_rvalid_o,
  output logic [DataWidth-1:0]   b_rdata_o,
  input  logic                   clear_i,
  output logic                   busy_o
);

  localparam int Depth      = 2 ** AddrWidth;
  localparam int BeWidth    = DataWidth / 8;
  localparam bit WriteFirst = (WriteMode == int'(WRITE_FIRST));

  localparam logic [AddrWidth:0] CntOne = {{AddrWidth{1'b0}}, 1'b1};
  localparam logic [AddrWidth:0] CntEnd = (AddrWidth + 1)'(Depth);

  if (((DataWidth % 8) != 0) || (DataWidth > MaxDataWidth)) begin : g_bad_data_width
    $error("sram_dp_ff: DataWidth must be a multiple of 8 and at most MaxDataWidth");
  end
  if ((ReadLatency < MinReadLatency) || (ReadLatency > MaxReadLatency)) begin : g_bad_latency
    $error("sram_dp_ff: ReadLatency out of range");
  end
  if ((WriteMode != 0) && (WriteMode != 1)) begin : g_bad_write_mode
    $error("sram_dp_ff: WriteMode must be 0 or 1");
  end

  function automatic logic [DataWidth-1:0] merge(input logic [DataWidth-1:0] old_w,
                                                 input logic [DataWidth-1:0] new_w,
                                                 input logic [BeWidth-1:0]   be);
    return DataWidth'(be_merge(word_max_t'(old_w), word_max_t'(new_w), be_max_t'(be)));
  endfunction

  logic [DataWidth-1:0] mem_q [Depth];

  clear_state_e       state_q, state_d;
  logic [AddrWidth:0] cnt_q, cnt_d;
  logic               clr_we;

  logic                 a_acc, b_acc, a_wr, b_wr, same_addr;
  logic [DataWidth-1:0] a_old, b_old, a_own, b_own, a_final, a_rsp, b_rsp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    busy_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        busy_o = 1'b1;
        clr_we = 1'b1;
        cnt_d  = cnt_q + CntOne;
        if (cnt_d == CntEnd) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign a_gnt_o = a_req_i & ~busy_o;
  assign b_gnt_o = b_req_i & ~busy_o;
  assign a_acc   = a_req_i & a_gnt_o;
  assign b_acc   = b_req_i & b_gnt_o;
  assign a_wr    = a_acc & a_we_i;
  assign b_wr    = b_acc & b_we_i;

  assign same_addr = (a_addr_i == b_addr_i);
  assign a_old     = mem_q[a_addr_i];
  assign b_old     = mem_q[b_addr_i];
  assign a_own     = merge(a_old, a_wdata_i, a_be_i);
  assign b_own     = merge(b_old, b_wdata_i, b_be_i);

  // On a same-address double write, A's lanes are layered over B's so A wins shared lanes.
  assign a_final = (b_wr && same_addr) ? merge(b_own, a_wdata_i, a_be_i) : a_own;

  // Write-first responses return the port's own merged word, independent of the other port.
  assign a_rsp = (WriteFirst && a_we_i) ? a_own : a_old;
  assign b_rsp = (WriteFirst && b_we_i) ? b_own : b_old;

  always_ff @(posedge clk_i) begin
    if (clr_we) mem_q[cnt_q[AddrWidth-1:0]] <= '0;
    if (b_wr)   mem_q[b_addr_i] <= b_own;
    if (a_wr)   mem_q[a_addr_i] <= a_final;
  end

  sram_rd_pipe #(
    .ReadLatency(ReadLatency),
    .DataWidth  (DataWidth)
  ) u_a_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .in_valid(a_acc),
    .in_data (a_rsp),
    .rvalid  (a_rvalid_o),
    .rdata   (a_rdata_o)
  );

  sram_rd_pipe #(
    .ReadLatency(ReadLatency),
    .DataWidth  (DataWidth)
  ) u_b_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .in_valid(b_acc),
    .in_data (b_rsp),
    .rvalid  (b_rvalid_o),
    .rdata   (b_rdata_o)
  );

endmodule

// File: tb/tb_sram_dp_ff.sv
// tb/tb_sram_dp_ff.sv - self-checking bench: read-first and write-first instances against a reference model
module tb_sram_dp_ff;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;
  localparam int LAT0  = 2;
  localparam int LAT1  = 3;

  logic          clk, rst, clear;
  logic          a_req, a_we, b_req, b_we;
  logic [BW-1:0] a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  logic [1:0]    a_gnt, b_gnt, a_rvalid, b_rvalid, busy;
  logic [DW-1:0] a_rdata [2];
  logic [DW-1:0] b_rdata [2];

  sram_dp_ff #(.AddrWidth(AW), .DataWidth(DW), .ReadLatency(LAT0), .WriteMode(0)) u_dut_rf (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_gnt_o(a_gnt[0]), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_rvalid_o(a_rvalid[0]), .a_rdata_o(a_rdata[0]),
    .b_req_i(b_req), .b_gnt_o(b_gnt[0]), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_rvalid_o(b_rvalid[0]), .b_rdata_o(b_rdata[0]),
    .clear_i(clear), .busy_o(busy[0])
  );

  sram_dp_ff #(.AddrWidth(AW), .DataWidth(DW), .ReadLatency(LAT1), .WriteMode(1)) u_dut_wf (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_gnt_o(a_gnt[1]), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_rvalid_o(a_rvalid[1]), .a_rdata_o(a_rdata[1]),
    .b_req_i(b_req), .b_gnt_o(b_gnt[1]), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_rvalid_o(b_rvalid[1]), .b_rdata_o(b_rdata[1]),
    .clear_i(clear), .busy_o(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: word array, clear progress and a per-cycle response schedule.
  logic [DW-1:0] mem_m [DEPTH];
  bit            busy_m;
  int            clr_idx;
  bit            pv [2][2][8];
  logic [DW-1:0] pd [2][2][8];
  logic [DW-1:0] last_d [2][2];

  int            resp_cnt [2][2];
  int            nz_cnt [2][2];
  logic [DW-1:0] got_d [2][2];
  int            obs_busy_n, gnt_busy_n;

  typedef struct {
    logic          we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rf;
    logic [DW-1:0] exp_wf;
  } vec_t;

  vec_t vecs [11];

  function automatic int lat_of(int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [DW-1:0] lane_merge(logic [DW-1:0] o, logic [DW-1:0] n, logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int k = 0; k < BW; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, idx, cyc, act, exp);
    end
  endtask

  task automatic reset_model();
    busy_m  = 1'b0;
    clr_idx = 0;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        last_d[i][p] = '0;
        for (int s = 0; s < 8; s++) pv[i][p][s] = 1'b0;
      end
  endtask

  task automatic clr_obs();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        resp_cnt[i][p] = 0;
        nz_cnt[i][p]   = 0;
      end
    obs_busy_n = 0;
    gnt_busy_n = 0;
  endtask

  task automatic model_edge();
    bit            acc_a, acc_b;
    logic [DW-1:0] old_a, old_b, own_a, own_b;
    acc_a = a_req && !busy_m;
    acc_b = b_req && !busy_m;
    old_a = mem_m[a_addr];
    old_b = mem_m[b_addr];
    own_a = lane_merge(old_a, a_wdata, a_be);
    own_b = lane_merge(old_b, b_wdata, b_be);
    for (int i = 0; i < 2; i++) begin
      int s;
      s = (cyc + lat_of(i)) % 8;
      if (acc_a) begin pv[i][0][s] = 1'b1; pd[i][0][s] = (i == 1 && a_we) ? own_a : old_a; end
      if (acc_b) begin pv[i][1][s] = 1'b1; pd[i][1][s] = (i == 1 && b_we) ? own_b : old_b; end
    end
    if (acc_b && b_we) mem_m[b_addr] = own_b;
    if (acc_a && a_we) mem_m[a_addr] = lane_merge(mem_m[a_addr], a_wdata, a_be);
    if (busy_m) begin
      mem_m[clr_idx] = '0;
      clr_idx++;
      if (clr_idx == DEPTH) begin busy_m = 1'b0; clr_idx = 0; end
    end else if (clear) begin
      busy_m  = 1'b1;
      clr_idx = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("busy", i, 64'(busy[i]), 64'(busy_m));
      chk("a_gnt", i, 64'(a_gnt[i]), 64'(a_req & ~busy_m));
      chk("b_gnt", i, 64'(b_gnt[i]), 64'(b_req & ~busy_m));
      for (int p = 0; p < 2; p++) begin
        int            s;
        bit            ev;
        logic          v;
        logic [DW-1:0] d;
        s  = cyc % 8;
        ev = pv[i][p][s];
        if (ev) begin last_d[i][p] = pd[i][p][s]; pv[i][p][s] = 1'b0; end
        v = (p == 0) ? a_rvalid[i] : b_rvalid[i];
        d = (p == 0) ? a_rdata[i] : b_rdata[i];
        chk(p == 0 ? "a_rvalid" : "b_rvalid", i, 64'(v), 64'(ev));
        chk(p == 0 ? "a_rdata" : "b_rdata", i, 64'(d), 64'(last_d[i][p]));
        if (v) begin
          resp_cnt[i][p]++;
          if (d != '0) nz_cnt[i][p]++;
          got_d[i][p] = d;
        end
      end
    end
    if (busy[0]) obs_busy_n++;
    if (busy[0] && (a_gnt[0] || b_gnt[0])) gnt_busy_n++;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_be = '0; b_addr = '0; b_wdata = '0;
    clear = 0;
  endtask

  task automatic run_clear_and_count(string name, bit hold_reads);
    clr_obs();
    a_req = hold_reads; b_req = hold_reads; a_we = 0; b_we = 0;
    clear = 1;
    tick();
    clear = 0;
    for (int k = 0; k < 24; k++) begin
      a_addr = AW'($urandom);
      b_addr = AW'($urandom);
      tick();
    end
    a_req = 0; b_req = 0;
    for (int k = 0; k < 5; k++) tick();
    chk(name, 0, 64'(obs_busy_n), 64'(DEPTH));
    chk("gnt_while_busy", 0, 64'(gnt_busy_n), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'hF, 4'h5, 32'h11223344, 32'h00000000, 32'h11223344};
    vecs[1]  = '{1'b0, 4'h0, 4'h5, 32'h00000000, 32'h11223344, 32'h11223344};
    vecs[2]  = '{1'b1, 4'hF, 4'h6, 32'hAABBCCDD, 32'h00000000, 32'hAABBCCDD};
    vecs[3]  = '{1'b1, 4'h1, 4'h6, 32'h00000011, 32'hAABBCCDD, 32'hAABBCC11};
    vecs[4]  = '{1'b0, 4'h0, 4'h6, 32'h00000000, 32'hAABBCC11, 32'hAABBCC11};
    vecs[5]  = '{1'b1, 4'hF, 4'hA, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 4'h0, 4'hA, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 4'h0, 4'hA, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[8]  = '{1'b0, 4'h0, 4'hA, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 4'hC, 4'h6, 32'h55660000, 32'hAABBCC11, 32'h5566CC11};
    vecs[10] = '{1'b0, 4'h0, 4'h6, 32'h00000000, 32'h5566CC11, 32'h5566CC11};

    idle_inputs();
    rst = 1;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, 64'(busy[i]), 64'(0));
      chk("rst_a_rvalid", i, 64'(a_rvalid[i]), 64'(0));
      chk("rst_b_rvalid", i, 64'(b_rvalid[i]), 64'(0));
      chk("rst_a_rdata", i, 64'(a_rdata[i]), 64'(0));
      chk("rst_b_rdata", i, 64'(b_rdata[i]), 64'(0));
    end
    rst = 0;
    tick();

    run_clear_and_count("first_clear_busy_cycles", 1'b0);

    foreach (vecs[k]) begin
      clr_obs();
      a_req = 1; a_we = vecs[k].we; a_be = vecs[k].be; a_addr = vecs[k].addr; a_wdata = vecs[k].wdata;
      tick();
      a_req = 0; a_we = 0;
      for (int w = 0; w < 5; w++) tick();
      for (int i = 0; i < 2; i++) begin
        chk("vec_resp_count", k, 64'(resp_cnt[i][0]), 64'(1));
        chk("vec_rdata", k, 64'(got_d[i][0]), 64'(i == 0 ? vecs[k].exp_rf : vecs[k].exp_wf));
      end
    end

    a_req = 1; a_we = 1; a_be = 4'b0011; a_addr = 4'h2; a_wdata = 32'h11111111;
    b_req = 1; b_we = 1; b_be = 4'b0110; b_addr = 4'h2; b_wdata = 32'h22222222;
    tick();
    clr_obs();
    a_we = 0; b_req = 0; b_we = 0;
    tick();
    a_req = 0;
    for (int w = 0; w < 5; w++) tick();
    for (int i = 0; i < 2; i++) chk("collision_read", i, 64'(got_d[i][0]), 64'(32'h00221111));

    a_req = 1; a_we = 1; a_be = 4'hF; a_addr = 4'h2; a_wdata = 32'hCAFEF00D;
    b_req = 1; b_we = 0; b_addr = 4'h2;
    tick();
    a_req = 0; a_we = 0; b_req = 0;
    for (int w = 0; w < 5; w++) tick();
    for (int i = 0; i < 2; i++) begin
      chk("cross_read_old", i, 64'(got_d[i][1]), 64'(32'h00221111));
      chk("cross_write_rsp", i, 64'(got_d[i][0]), 64'(i == 0 ? 32'h00221111 : 32'hCAFEF00D));
    end

    for (int w = 0; w < DEPTH; w++) begin
      a_req = 1; a_we = 1; a_be = 4'hF; a_addr = AW'(w); a_wdata = 32'hFFFFFFFF;
      tick();
    end
    a_req = 0; a_we = 0;
    for (int w = 0; w < 5; w++) tick();
    run_clear_and_count("fill_clear_busy_cycles", 1'b1);

    clr_obs();
    for (int w = 0; w < DEPTH; w++) begin
      a_req = 1; a_addr = AW'(w); b_req = 1; b_addr = AW'(DEPTH - 1 - w);
      tick();
    end
    a_req = 0; b_req = 0;
    for (int w = 0; w < 5; w++) tick();
    for (int i = 0; i < 2; i++) begin
      chk("after_clear_a_count", i, 64'(resp_cnt[i][0]), 64'(DEPTH));
      chk("after_clear_a_nonzero", i, 64'(nz_cnt[i][0]), 64'(0));
      chk("after_clear_b_nonzero", i, 64'(nz_cnt[i][1]), 64'(0));
    end

    for (int n = 0; n < 300; n++) begin
      a_req = ($urandom_range(0, 3) != 0); a_we = 1'($urandom); a_be = BW'($urandom);
      a_addr = AW'($urandom); a_wdata = $urandom;
      b_req = ($urandom_range(0, 3) != 0); b_we = 1'($urandom); b_be = BW'($urandom);
      b_addr = ($urandom_range(0, 2) == 0) ? a_addr : AW'($urandom); b_wdata = $urandom;
      clear = ($urandom_range(0, 59) == 0);
      tick();
    end
    idle_inputs();
    for (int w = 0; w < 20; w++) tick();

    clear = 1;
    tick();
    clear = 0;
    for (int w = 0; w < 4; w++) tick();
    rst = 1;
    reset_model();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("midclear_rst_busy", i, 64'(busy[i]), 64'(0));
      chk("midclear_rst_a_rvalid", i, 64'(a_rvalid[i]), 64'(0));
      chk("midclear_rst_b_rvalid", i, 64'(b_rvalid[i]), 64'(0));
    end
    tick();
    tick();
    rst = 0;
    a_req = 1; a_addr = 4'h0;
    #1;
    for (int i = 0; i < 2; i++) chk("gnt_after_rst", i, 64'(a_gnt[i]), 64'(1));
    tick();
    a_req = 0;
    for (int w = 0; w < 5; w++) tick();
    run_clear_and_count("reclear_busy_cycles", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_dp_ff.md
Name: sram_dp_ff

Overview:
- Parametrised true dual-port flop-based SRAM model, successor to the single-port byte-write RAM in the FPGA testbench memory subsystem.
- Two independent request/grant ports (A, B) with OBI-style rvalid, configurable read latency, selectable read-during-write mode and a sequential hardware clear engine.
- Serves as instruction/data memory for cv32e40p FPGA benches, where one port serves the core and one serves the loader/debug.

Parameters:
AddrWidth, 11, word address width; Depth = 2**AddrWidth words
DataWidth, 32, word width; must be a multiple of 8 (elaboration-time error otherwise)
ReadLatency, 1, cycles from accepted request to rvalid; legal 1..4
WriteMode, 0, same-port read-during-write: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (merged new data)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
a_req_i  in  1  port A request
a_gnt_o  out  1  port A grant (combinational)
a_we_i  in  1  port A write enable (1 = write)
a_be_i  in  DataWidth/8  port A byte enables (writes only)
a_addr_i  in  AddrWidth  port A word address
a_wdata_i  in  DataWidth  port A write data
a_rvalid_o  out  1  port A response valid
a_rdata_o  out  DataWidth  port A response data
b_req_i, b_gnt_o, b_we_i, b_be_i, b_addr_i, b_wdata_i, b_rvalid_o, b_rdata_o  same as port A, for port B
clear_i  in  1  start zero-fill of whole array (pulse)
busy_o  out  1  clear in progress

Behaviour:
- Reset: a/b_rvalid_o = 0, a/b_rdata_o = 0, busy_o = 0, FSM = IDLE, clear counter = 0, pipeline valids = 0. Array contents are not reset.
- Grant: x_gnt_o = x_req_i & ~busy_o. A request is accepted when x_req_i & x_gnt_o; address, data, we and be are sampled on that edge.
- Response: every accepted request (read or write) produces exactly one x_rvalid_o pulse, exactly ReadLatency cycles after acceptance.
  - Back-to-back acceptance gives back-to-back rvalid; there is no stall and no response backpressure.
- rdata for a read: word contents per the rules below. rdata for a write: old word when WriteMode = 0, merged word when WriteMode = 1.
- x_rdata_o holds its last value between rvalid pulses.
- Write: only lanes with be[i] = 1 are updated. be = 0 with we = 1 is a legal no-op write that still returns rvalid.
- Cross-port, same address, same cycle:
  - Read on one port and write on the other: the reader always sees pre-write contents.
  - Both ports write: lanes enabled on both take port A data; lanes enabled on one port only take that port's data.
- Clear FSM:
  - IDLE: clear_i = 1 goes to CLEAR next cycle; busy_o = 1 from that cycle.
  - CLEAR: writes zero to word[cnt] each cycle, cnt counting 0..Depth-1; after the cnt = Depth-1 write, returns to IDLE and busy_o = 0. busy_o is high for exactly Depth cycles.
- Clear boundary cases:
  - clear_i in CLEAR is ignored.
  - Requests in the same cycle as clear_i in IDLE are granted and serviced.
  - In-flight responses complete normally during CLEAR, carrying data captured before the clear writes.
- Reset mid-clear: FSM to IDLE, busy_o = 0; array partially cleared and contents undefined-but-stable.
- cnt is AddrWidth+1 bits, so the Depth terminal value is detectable without wrap ambiguity.

Decomposition:
- Package sram_pkg holds:
  - the write_mode_e enum (READ_FIRST, WRITE_FIRST);
  - the clear_state_e enum (IDLE, CLEAR);
  - a be_merge(old, new, be) function;
  - parameter legality check constants.
- Sub-module sram_rd_pipe (params ReadLatency, DataWidth): valid/data shift register with async reset. It takes a valid and data at stage 0 and emits rvalid/rdata at stage ReadLatency. It is instantiated once per port.

Test Plan:
- Reset, then A write 0x11223344 to addr 0x005 with be = 4'hF, then A read addr 0x005 with ReadLatency = 2 -> a_rvalid_o high exactly 2 cycles after read acceptance, a_rdata_o = 0x11223344.
- Partial write: word = 0xAABBCCDD, A write 0x00000011 with be = 4'b0001, then read -> 0xAABBCC11.
- Same-port read-during-write at addr 0x010 holding 0x0: write 0xDEADBEEF -> write response rdata = 0x0 when WriteMode = 0, 0xDEADBEEF when WriteMode = 1.
- Dual write collision at addr 0x020: A writes 0x11111111 with be = 4'b0011, B writes 0x22222222 with be = 4'b0110 -> subsequent read 0x00221111; same cycle, B read at addr 0x020 returns the prior contents.
- Clear with AddrWidth = 4: fill all 16 words with 0xFFFFFFFF, pulse clear_i -> busy_o high exactly 16 cycles, a/b_gnt_o = 0 throughout, then all 16 reads return 0x0.
- Assert rst_i during cycle 5 of a clear, then release -> busy_o = 0 and rvalid = 0 immediately, gnt resumes, and a new clear completes in 16 cycles.
